// File: rtl/aes_round_engine_if.sv
// ---------------------------------------------------------------------------
// aes_round_engine_if
//   Bundles the block-stream handshake, the round-key store lookup and the
//   result handshake of the iterative AES engine.
//   Signals:
//     in_valid / in_ready / encrypt / input_block : block acceptance
//     key_idx / round_key                         : round-key store lookup
//     out_valid / out_ready / output_block        : result handshake
//     busy                                        : engine not idle
//   Modports:
//     master : front end + key store (drives inputs, reads status)
//     slave  : the engine
// ---------------------------------------------------------------------------
interface aes_round_engine_if #(
  parameter int KIDX_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              encrypt;
  logic [127:0]      input_block;
  logic [KIDX_W-1:0] key_idx;
  logic [127:0]      round_key;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      output_block;
  logic              busy;

  modport master (
    output in_valid, encrypt, input_block, round_key, out_ready,
    input  in_ready, key_idx, out_valid, output_block, busy
  );

  modport slave (
    input  in_valid, encrypt, input_block, round_key, out_ready,
    output in_ready, key_idx, out_valid, output_block, busy
  );
endinterface

// File: rtl/aes_round_engine.sv
// ---------------------------------------------------------------------------
// aes_round_engine
//   Iterative AES core. One shared round datapath (forward or inverse,
//   selected per block) is applied NR times to a 128-bit state register.
//   Round keys come from an external store addressed by key_idx and are
//   expected back combinationally in the same cycle.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset
//     bus     : aes_round_engine_if.slave (handshakes, key lookup, result)
//   Parameters:
//     NR      : rounds, 10 / 12 / 14 (AES-128/192/256)
//     KIDX_W  : key index width, 2**KIDX_W > NR
// ---------------------------------------------------------------------------
module aes_round_engine #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  aes_round_engine_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if ((2 ** KIDX_W) <= NR) begin : g_bad_kidx
    $error("aes_round_engine: KIDX_W too narrow for NR");
  end

  localparam logic [KIDX_W-1:0] NR_K   = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] ZERO_K = {KIDX_W{1'b0}};
  localparam logic [KIDX_W-1:0] ONE_K  = KIDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // ---------------- GF(2^8) helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Forward and inverse S-box share one field inverter; only the affine
  // step moves to the other side of it.
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic enc);
    logic [7:0] pre;
    logic [7:0] g;
    pre = enc ? b : ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    g   = gf_inv(pre);
    return enc ? (g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^
                  {g[3:0], g[7:4]} ^ 8'h63)
               : g;
  endfunction

  function automatic logic [7:0] mc_coef(input int j, input logic inv);
    case (j)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  // One column of (Inv)MixColumns; the matrix is circulant, so row ri uses
  // coefficient (k - ri) mod 4 for input byte k.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] r [4];
    for (int ri = 0; ri < 4; ri++) begin
      r[ri] = 8'h00;
      for (int k = 0; k < 4; k++) begin
        r[ri] = r[ri] ^ gf_mul(mc_coef((k - ri + 4) % 4, inv), col[31-8*k -: 8]);
      end
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // ---------------- state ----------------
  state_e            state_q;
  logic [KIDX_W-1:0] ctr_q;
  logic              mode_q;
  logic [127:0]      st_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [127:0]      sub_s;
  logic [127:0]      shift_s;
  logic [127:0]      mix_in_s;
  logic [127:0]      mix_out_s;
  logic [127:0]      st_rnd_d;
  logic [KIDX_W-1:0] key_idx_s;
  logic              last_s;

  assign last_s = (ctr_q == NR_K);

  // Byte substitution of the whole state, direction from the latched mode
  always_comb begin
    sub_s = 128'h0;
    for (int i = 0; i < 16; i++) begin
      sub_s[127-8*i -: 8] = sub_byte(st_q[127-8*i -: 8], mode_q);
    end
  end

  // Row shift: byte r+4c is state[r][c]; row r rotates left (enc) or right (dec) by r
  always_comb begin
    shift_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[127-8*(r+4*c) -: 8] =
          sub_s[127-8*(r+4*(mode_q ? ((c + r) % 4) : ((c + 4 - r) % 4))) -: 8];
      end
    end
  end

  // Column mix and key add; decrypt adds the key before mixing, final round skips the mix
  always_comb begin
    mix_in_s  = mode_q ? shift_s : (shift_s ^ bus.round_key);
    mix_out_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      mix_out_s[127-32*c -: 32] = mix_col(mix_in_s[127-32*c -: 32], !mode_q);
    end
    if (last_s) begin
      st_rnd_d = mode_q ? (shift_s ^ bus.round_key) : mix_in_s;
    end else begin
      st_rnd_d = mode_q ? (mix_out_s ^ bus.round_key) : mix_out_s;
    end
  end

  // Round-key request; in IDLE it follows the live Encrypt so the whitening key is ready on accept
  always_comb begin
    case (state_q)
      S_IDLE:  key_idx_s = bus.encrypt ? ZERO_K : NR_K;
      S_ROUND: key_idx_s = mode_q ? ctr_q : (NR_K - ctr_q);
      S_DONE:  key_idx_s = ZERO_K;
      default: key_idx_s = ZERO_K;
    endcase
  end

  // Control FSM with registered handshake/status outputs and the state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ctr_q       <= ZERO_K;
      mode_q      <= 1'b1;
      st_q        <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            st_q       <= bus.input_block ^ bus.round_key;
            mode_q     <= bus.encrypt;
            ctr_q      <= ONE_K;
            state_q    <= S_ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_ROUND: begin
          st_q <= st_rnd_d;
          if (last_s) begin
            state_q     <= S_DONE;
            ctr_q       <= ZERO_K;
            out_valid_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + ONE_K;
          end
        end
        S_DONE: begin
          // A simultaneous in_valid is not taken here; IDLE accepts it next cycle
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          ctr_q       <= ZERO_K;
          mode_q      <= 1'b1;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.output_block = st_q;
  assign bus.key_idx      = key_idx_s;

endmodule

// File: tb/tb_aes_round_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_round_engine
//   Drives three engines (NR = 10, 12, 14) from one set of stimulus signals,
//   each backed by its own round-key store expanded here from the cipher key.
//   Known-answer vectors sit in a table; expected results go into a queue
//   at acceptance and are popped when the engine raises out_valid.
// ---------------------------------------------------------------------------
module tb_aes_round_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic         in_valid;
  logic         encrypt;
  logic         out_ready;
  logic [127:0] input_block;
  int           sel;

  logic [127:0] rk [3][16];
  logic [127:0] exp_q [$];

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_round_engine_if #(.KIDX_W(4)) if0 ();
  aes_round_engine_if #(.KIDX_W(4)) if1 ();
  aes_round_engine_if #(.KIDX_W(4)) if2 ();

  aes_round_engine #(.NR(10), .KIDX_W(4)) dut10 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  aes_round_engine #(.NR(12), .KIDX_W(4)) dut12 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  aes_round_engine #(.NR(14), .KIDX_W(4)) dut14 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  assign if0.in_valid = in_valid && (sel == 0);
  assign if1.in_valid = in_valid && (sel == 1);
  assign if2.in_valid = in_valid && (sel == 2);
  assign if0.encrypt = encrypt;
  assign if1.encrypt = encrypt;
  assign if2.encrypt = encrypt;
  assign if0.input_block = input_block;
  assign if1.input_block = input_block;
  assign if2.input_block = input_block;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign if0.round_key = rk[0][if0.key_idx];
  assign if1.round_key = rk[1][if1.key_idx];
  assign if2.round_key = rk[2][if2.key_idx];

  logic         m_in_ready, m_out_valid, m_busy;
  logic [3:0]   m_key_idx;
  logic [127:0] m_out;

  // Route the selected engine's outputs to one set of observation signals
  always_comb begin
    case (sel)
      1: begin
        m_in_ready = if1.in_ready; m_out_valid = if1.out_valid; m_busy = if1.busy;
        m_key_idx = if1.key_idx; m_out = if1.output_block;
      end
      2: begin
        m_in_ready = if2.in_ready; m_out_valid = if2.out_valid; m_busy = if2.busy;
        m_key_idx = if2.key_idx; m_out = if2.output_block;
      end
      default: begin
        m_in_ready = if0.in_ready; m_out_valid = if0.out_valid; m_busy = if0.busy;
        m_key_idx = if0.key_idx; m_out = if0.output_block;
      end
    endcase
  end

  typedef struct {
    int           d;
    logic         enc;
    logic [255:0] key;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [8];

  function automatic int nr_of(input int d);
    return 10 + 2 * d;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Standard AES key expansion into the key store of engine d
  task automatic expand(input int d, input logic [255:0] key);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * d;
    nr = nr_of(d);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) rk[d][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic start_block(input vec_t v);
    expand(v.d, v.key);
    @(negedge clk);
    sel = v.d; encrypt = v.enc; input_block = v.din; in_valid = 1'b1;
    #1;
    chk("in_ready_idle", m_in_ready, 1'b1);
    chk("key_idx_idle", m_key_idx, v.enc ? 0 : nr_of(v.d));
    exp_q.push_back(v.dout);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic rounds(input vec_t v, input bit toggle, input int stop_at);
    int nr;
    nr = nr_of(v.d);
    for (int r = 1; r <= nr; r++) begin
      @(negedge clk); #1;
      if (stop_at == r) return;
      chk("key_idx_round", m_key_idx, v.enc ? r : nr - r);
      chk("busy_round", m_busy, 1'b1);
      if (r == nr) chk("out_valid_early", m_out_valid, 1'b0);
      if (toggle) encrypt = ~encrypt;
    end
  endtask

  task automatic finish_block(input int hold);
    int waited;
    logic [127:0] exp_v;
    waited = 0;
    exp_v = 128'h0;
    @(negedge clk); #1;
    while (m_out_valid !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("latency_extra_cycles", waited, 0);
    chk("scoreboard_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("output_block", m_out, exp_v);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk); #1;
      chk("hold_output", m_out, exp_v);
      chk("hold_in_ready", m_in_ready, 1'b0);
      chk("hold_out_valid", m_out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release_in_ready", m_in_ready, 1'b1);
    chk("release_out_valid", m_out_valid, 1'b0);
    chk("release_busy", m_busy, 1'b0);
    chk("release_output", m_out, exp_v);
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C14 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  // Global time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main test sequence
  initial begin
    vecs[0] = '{d: 0, enc: 1'b1, key: K128, din: PT,  dout: C10};
    vecs[1] = '{d: 0, enc: 1'b0, key: K128, din: C10, dout: PT};
    vecs[2] = '{d: 1, enc: 1'b1, key: K192, din: PT,  dout: C12};
    vecs[3] = '{d: 1, enc: 1'b0, key: K192, din: C12, dout: PT};
    vecs[4] = '{d: 2, enc: 1'b1, key: K256, din: PT,  dout: C14};
    vecs[5] = '{d: 2, enc: 1'b0, key: K256, din: C14, dout: PT};
    vecs[6] = '{d: 0, enc: 1'b1, key: KB,   din: PTB, dout: CB};
    vecs[7] = '{d: 0, enc: 1'b0, key: KB,   din: CB,  dout: PTB};

    rst_n = 1'b0; in_valid = 1'b0; encrypt = 1'b1; out_ready = 1'b0;
    sel = 0; input_block = 128'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", m_in_ready, 1'b1);
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_output", m_out, 128'h0);
    chk("rst_key_idx_enc", m_key_idx, 4'd0);
    encrypt = 1'b0;
    #1;
    chk("rst_key_idx_dec", m_key_idx, 4'd10);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer table, every engine, both directions
    for (int i = 0; i < 8; i++) begin
      start_block(vecs[i]);
      rounds(vecs[i], 1'b0, 0);
      finish_block(0);
    end

    // Encrypt toggling while a block is in flight must not disturb it
    start_block(vecs[0]);
    rounds(vecs[0], 1'b1, 0);
    finish_block(0);

    // Back-pressure in DONE with in_valid held high, then the second block
    start_block(vecs[0]);
    rounds(vecs[0], 1'b0, 0);
    finish_block(6);
    encrypt = 1'b1;
    input_block = PT;
    exp_q.push_back(C10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("second_accept_busy", m_busy, 1'b1);
    chk("second_accept_in_ready", m_in_ready, 1'b0);
    rounds(vecs[0], 1'b0, 0);
    finish_block(0);

    // Asynchronous reset in the middle of round 5
    start_block(vecs[0]);
    rounds(vecs[0], 1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", m_out_valid, 1'b0);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_output", m_out, 128'h0);
    chk("midrst_in_ready", m_in_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_block(vecs[0]);
    rounds(vecs[0], 1'b0, 0);
    finish_block(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
